// File: rtl/piso_ser.sv
// piso_ser: parallel-in / serial-out frame serializer.
//
// A parallel word of N bits is captured on a load handshake and then emitted
// one bit per cycle on ser_out, qualified by ser_en, in the bit order chosen
// by dir at load time (0 = MSB first, 1 = LSB first). ser_dir carries the
// latched order so a downstream shift register can follow it. ser_last marks
// the final cycle of a frame. A new word may be accepted on that final cycle,
// which gives gap-free back-to-back frames.
//
// Optional feature: define PISO_SER_PARITY_EN to append one even-parity cycle
// (XOR of the captured word) after the data bits. The frame is then N+1
// cycles long and ser_last marks the parity cycle.
//
// Handshake: a word is transferred on every rising clk edge where
// load_valid && load_ready are both 1. load_ready depends only on registered
// state, so it never combinationally reflects load_valid. While load_ready is
// 0, load_valid, load_data and dir are ignored.
//
// ser_out, ser_en, ser_last and ser_dir all come straight from flops. rst_n is
// synchronous and active-low, and it wins over a load offered on the same edge.
//
// dbg_state exposes the FSM state encoding for monitors and checkers.

module piso_ser #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [N-1:0] load_data,
    input  logic         dir,
    output logic         ser_out,
    output logic         ser_en,
    output logic         ser_dir,
    output logic         ser_last,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef PISO_SER_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sreg_q, sreg_d;    // bits still to be emitted, next bit at the active end
    logic [CW-1:0]  cnt_q, cnt_d;      // data bits remaining after the one on ser_out
    logic           out_q, out_d;
    logic           en_q, en_d;
    logic           last_q, last_d;
    logic           dir_q, dir_d;
    logic           load_accept;
`ifdef PISO_SER_PARITY_EN
    logic           par_q, par_d;      // even parity of the captured word
`endif

    // A word is taken only when idle or on the last cycle of the current frame.
    assign load_ready  = (state_q == IDLE) || last_q;
    assign load_accept = load_valid && load_ready;

    assign ser_out   = out_q;
    assign ser_en    = en_q;
    assign ser_last  = last_q;
    assign ser_dir   = dir_q;
    assign dbg_state = state_q;

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            en_q    <= 1'b0;
            last_q  <= 1'b0;
            dir_q   <= 1'b0;
`ifdef PISO_SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            en_q    <= en_d;
            last_q  <= last_d;
            dir_q   <= dir_d;
`ifdef PISO_SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state and next-output logic; the serial outputs for the coming cycle
    // are computed here and registered above.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        out_d   = 1'b0;
        en_d    = 1'b0;
        last_d  = 1'b0;
        dir_d   = dir_q;
`ifdef PISO_SER_PARITY_EN
        par_d   = par_q;
`endif

        if (load_accept) begin
            // First bit goes out on the cycle after the load edge; the rest
            // of the word is kept pre-shifted so the next bit sits at the end.
            state_d = SHIFT;
            dir_d   = dir;
            en_d    = 1'b1;
            cnt_d   = CW'(N - 1);
            if (dir) begin
                out_d  = load_data[0];
                sreg_d = load_data >> 1;
            end else begin
                out_d  = load_data[N-1];
                sreg_d = load_data << 1;
            end
`ifdef PISO_SER_PARITY_EN
            par_d   = ^load_data;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q != '0) begin
                        en_d  = 1'b1;
                        cnt_d = cnt_q - CW'(1);
                        if (dir_q) begin
                            out_d  = sreg_q[0];
                            sreg_d = sreg_q >> 1;
                        end else begin
                            out_d  = sreg_q[N-1];
                            sreg_d = sreg_q << 1;
                        end
`ifdef PISO_SER_PARITY_EN
                        last_d = 1'b0;
`else
                        last_d = (cnt_q == CW'(1));
`endif
                    end else begin
`ifdef PISO_SER_PARITY_EN
                        // Data bits done: emit the parity bit as the frame's last cycle.
                        state_d = PARITY;
                        en_d    = 1'b1;
                        out_d   = par_q;
                        last_d  = 1'b1;
`else
                        state_d = IDLE;
`endif
                    end
                end
`ifdef PISO_SER_PARITY_EN
                PARITY: begin
                    state_d = IDLE;
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_ser.sv
// tb_piso_ser: directed self-checking bench for piso_ser (N=16).
// Follows PISO_SER_PARITY_EN when it is defined for the build.

module tb_piso_ser;

    localparam int N = 16;
`ifdef PISO_SER_PARITY_EN
    localparam int FL = N + 1;
`else
    localparam int FL = N;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [N-1:0] load_data = '0;
    logic         dir = 1'b0;
    logic         ser_out;
    logic         ser_en;
    logic         ser_dir;
    logic         ser_last;
    logic [1:0]   dbg_state;

    int errors = 0;
    int checks = 0;

    piso_ser #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .dir        (dir),
        .ser_out    (ser_out),
        .ser_en     (ser_en),
        .ser_dir    (ser_dir),
        .ser_last   (ser_last),
        .dbg_state  (dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_dir);
        check({tag, "_en"},    32'(ser_en),     32'd0);
        check({tag, "_out"},   32'(ser_out),    32'd0);
        check({tag, "_last"},  32'(ser_last),   32'd0);
        check({tag, "_ready"}, 32'(load_ready), 32'd1);
        check({tag, "_dir"},   32'(ser_dir),    32'(exp_dir));
    endtask

    // Checks a full frame starting at the current cycle (first bit on ser_out).
    // lv_last drives load_valid for the edge ending the last cycle; with noise
    // set, a zero word and toggling dir are offered during the busy cycles.
    task automatic expect_frame(input logic [N-1:0] w, input logic d,
                                input logic lv_last, input logic noise,
                                input string tag);
        logic [N-1:0] rx;
        logic         eb;
        logic         el;
        rx = '0;
        for (int i = 0; i < FL; i++) begin
            if (i < N) eb = d ? w[i] : w[N-1-i];
            else       eb = ^w;
            el = (i == FL - 1);
            check($sformatf("%s_en%0d", tag, i),    32'(ser_en),     32'd1);
            check($sformatf("%s_bit%0d", tag, i),   32'(ser_out),    32'(eb));
            check($sformatf("%s_last%0d", tag, i),  32'(ser_last),   32'(el));
            check($sformatf("%s_ready%0d", tag, i), 32'(load_ready), 32'(el));
            check($sformatf("%s_dir%0d", tag, i),   32'(ser_dir),    32'(d));
            if (i < N) begin
                if (d) rx = {ser_out, rx[N-1:1]};
                else   rx = {rx[N-2:0], ser_out};
            end
            if (el) begin
                load_valid = lv_last;
            end else if (noise) begin
                load_valid = 1'b1;
                load_data  = '0;
                dir        = ~dir;
            end
            step();
        end
        check({tag, "_rx"}, 32'(rx), 32'(w));
    endtask

    initial begin
        // Reset state.
        rst_n = 1'b0;
        step();
        step();
        check_idle("reset", 1'b0);
        rst_n = 1'b1;
        step();
        check_idle("post_reset", 1'b0);

        // A5C3 MSB first: 1010 0101 1100 0011.
        load_data  = 16'hA5C3;
        dir        = 1'b0;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        expect_frame(16'hA5C3, 1'b0, 1'b0, 1'b0, "msb");
        check_idle("msb_after", 1'b0);

        // A5C3 LSB first: 1100 0011 1010 0101, right-shift receiver rebuilds A5C3.
        load_data  = 16'hA5C3;
        dir        = 1'b1;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        expect_frame(16'hA5C3, 1'b1, 1'b0, 1'b0, "lsb");
        check_idle("lsb_after", 1'b1);
        step();
        check_idle("lsb_hold", 1'b1);

        // Back-to-back: 1234 then FFFF with load_valid held high.
        load_data  = 16'h1234;
        dir        = 1'b0;
        load_valid = 1'b1;
        step();
        load_data  = 16'hFFFF;
        expect_frame(16'h1234, 1'b0, 1'b1, 1'b0, "b2b_a");
        expect_frame(16'hFFFF, 1'b0, 1'b0, 1'b0, "b2b_b");
        check_idle("b2b_after", 1'b0);

        // Inputs churn during a busy FFFF frame: must be ignored.
        load_data  = 16'hFFFF;
        dir        = 1'b0;
        load_valid = 1'b1;
        step();
        expect_frame(16'hFFFF, 1'b0, 1'b0, 1'b1, "noise");
        check_idle("noise_after", 1'b0);
        step();
        check_idle("noise_no_extra", 1'b0);
        dir = 1'b0;

        // Reset during the 7th bit, with a load offered on the reset edge.
        load_data  = 16'h1234;
        dir        = 1'b1;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check("mid_bit7_en",  32'(ser_en),  32'd1);
        check("mid_bit7_out", 32'(ser_out), 32'(16'h1234 >> 6) & 32'd1);
        rst_n      = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'h5555;
        step();
        check_idle("mid_reset", 1'b0);
        rst_n      = 1'b1;
        load_valid = 1'b0;
        step();
        check_idle("mid_discard", 1'b0);

        // Fresh frame after reset: 8001 MSB first = 1,0,...,0,1.
        load_data  = 16'h8001;
        dir        = 1'b0;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        expect_frame(16'h8001, 1'b0, 1'b0, 1'b0, "fresh");
        check_idle("fresh_after", 1'b0);

`ifdef PISO_SER_PARITY_EN
        // Parity: 0001 -> parity bit 1, 0003 -> parity bit 0.
        load_data  = 16'h0001;
        dir        = 1'b0;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        expect_frame(16'h0001, 1'b0, 1'b0, 1'b0, "par1");
        check_idle("par1_after", 1'b0);
        load_data  = 16'h0003;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        expect_frame(16'h0003, 1'b0, 1'b0, 1'b0, "par0");
        check_idle("par0_after", 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_ser.md
PISO_SER -- requirements
Module: piso_ser

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning serial frame data width in bits; legal range N >= 2.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port load_valid  input  1  parallel word offered.
REQ-005 The block SHALL have port load_ready  output  1  block can accept a word this cycle.
REQ-006 The block SHALL have port load_data  input  N  parallel word to serialize.
REQ-007 The block SHALL have port dir  input  1  bit order, sampled at load: 0 = MSB first (pairs with left-shifting receiver), 1 = LSB first (pairs with right-shifting receiver).
REQ-008 The block SHALL have port ser_out  output  1  serial data bit; drives receiver d_in.
REQ-009 The block SHALL have port ser_en  output  1  ser_out valid this cycle; drives receiver shift_en.
REQ-010 The block SHALL have port ser_dir  output  1  latched dir of the current frame; drives receiver dir.
REQ-011 The block SHALL have port ser_last  output  1  high during final bit of a frame.

Function
REQ-012 The block SHALL implement FSM states IDLE, SHIFT, plus PARITY when PISO_SER_PARITY_EN is defined.
REQ-013 A load SHALL occur on any rising edge where load_valid && load_ready; load_data and dir are captured into an internal shift register and ser_dir.
REQ-014 load_ready SHALL be 1 in IDLE, and 1 during the final cycle of a frame (ser_last=1), otherwise 0.
REQ-015 After a load, FSM SHALL be in SHIFT the next cycle; ser_en=1 with the first bit (load_data[N-1] if dir=0, load_data[0] if dir=1); latency load edge to first bit = 1 cycle.
REQ-016 In SHIFT, one bit SHALL be emitted per cycle for exactly N consecutive cycles, tracked by a bit counter of width $clog2(N+1); no gaps.
REQ-017 ser_last SHALL be 1 exactly on the Nth data bit (parity disabled) or the parity cycle (parity enabled).
REQ-018 If a load occurs on the ser_last cycle, the next frame's first bit SHALL follow in the next cycle (back-to-back, ser_en stays 1); otherwise FSM SHALL return to IDLE.
REQ-019 In IDLE, ser_en, ser_out and ser_last SHALL be 0; ser_dir SHALL hold its last value.
REQ-020 load_valid, load_data and dir changes while load_ready=0 SHALL be ignored; the in-flight frame is unaffected.
REQ-021 All outputs SHALL be registered (no combinational path from inputs to ser_out/ser_en/ser_last), except load_ready, which may depend only on state.

Reset
REQ-022 On a rising clk edge with rst_n=0, the block SHALL enter IDLE, clear shift register and counter, and drive ser_out=0, ser_en=0, ser_last=0, ser_dir=0, load_ready=1 from the following cycle.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no further ser_en pulses; a load presented together with reset SHALL be discarded.

Configuration
REQ-024 When macro PISO_SER_PARITY_EN is defined, after the N data bits the block SHALL emit one PARITY cycle with ser_en=1 and ser_out = XOR of the captured word (even parity), frame length N+1.
REQ-025 When PISO_SER_PARITY_EN is undefined, the PARITY state and logic SHALL be absent and frame length SHALL be N.

Verification
REQ-026 N=16, load 16'hA5C3, dir=0 -> ser_out 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on 16 consecutive ser_en cycles starting one cycle after load, ser_last on the 16th, ser_dir=0.
REQ-027 Load 16'hA5C3, dir=1 -> ser_out 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, ser_dir=1; a right-shifting receiver then holds 16'hA5C3.
REQ-028 load_valid held high with 16'h1234 then 16'hFFFF -> ser_en high for 32 contiguous cycles, load_ready pulses only on the two ser_last cycles.
REQ-029 Reset asserted during 7th bit -> ser_en=0, ser_last=0, load_ready=1 next cycle; a fresh load of 16'h8001, dir=0 then emits 1,0,...,0,1.
REQ-030 load_valid=1 with 16'h0000 and dir toggling during an active 16'hFFFF frame -> ignored, all 16 bits are 1, no extra frame.
REQ-031 With PISO_SER_PARITY_EN, load 16'h0001 dir=0 -> 17 ser_en cycles, 17th bit =1 with ser_last; 16'h0003 -> 17th bit =0.
